// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared constants for the branch history table / BTB.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int DEFAULT_ENTRIES = 64;
    localparam int DEFAULT_IDX_W   = 6;
    localparam int DEFAULT_TAG_W   = 8;

    // Instructions are word aligned, so the index starts above pc[1:0].
    localparam int PC_IDX_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter2
//  Description : 2-bit saturating up/down counter next-state logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nextCtr
);

    always_comb begin
        nextCtr = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                nextCtr = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nextCtr = ctr - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Direct-mapped BHT + BTB with zero-latency fetch lookup,
//                execute-stage training and branch/mispredict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = DEFAULT_ENTRIES,
    parameter int         IDX_W    = DEFAULT_IDX_W,
    parameter int         TAG_W    = DEFAULT_TAG_W,
    parameter logic [1:0] INIT_CTR = CTR_WNT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        predict_taken_f,
    output logic [31:0] predict_target_f,
    output logic        btb_hit_f,
    input  logic        update_en_e,
    input  logic [31:0] pc_e,
    input  logic        taken_e,
    input  logic [31:0] target_e,
    input  logic        mispredict_e,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int c_TAG_LSB = PC_IDX_LSB + IDX_W;
    localparam int c_TAG_MSB = c_TAG_LSB + TAG_W - 1;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_branchCount;
    logic [31:0]        r_mispredictCount;

    logic [IDX_W-1:0]   w_idxF;
    logic [TAG_W-1:0]   w_tagF;
    logic               w_hitF;
    logic [IDX_W-1:0]   w_idxE;
    logic [TAG_W-1:0]   w_tagE;
    logic               w_hitE;
    logic [1:0]         w_satNext;
    logic [1:0]         w_ctrWrite;
    logic               w_unusedLow;

    assign w_idxF = pc_f[c_TAG_LSB-1:PC_IDX_LSB];
    assign w_tagF = pc_f[c_TAG_MSB:c_TAG_LSB];
    assign w_idxE = pc_e[c_TAG_LSB-1:PC_IDX_LSB];
    assign w_tagE = pc_e[c_TAG_MSB:c_TAG_LSB];

    assign w_unusedLow = ^{pc_f[1:0], pc_e[1:0]};

    generate
        if (c_TAG_MSB < 31) begin : g_unusedHigh
            logic w_unusedHighBits;
            assign w_unusedHighBits = ^{pc_f[31:c_TAG_MSB+1], pc_e[31:c_TAG_MSB+1]};
        end
    endgenerate

    // Fetch lookup reads the table as it stood before this cycle's update.
    assign w_hitF           = !rst && r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
    assign btb_hit_f        = w_hitF;
    assign predict_taken_f  = w_hitF && r_ctr[w_idxF][1];
    assign predict_target_f = w_hitF ? r_target[w_idxF] : 32'd0;

    assign w_hitE = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);

    sat_counter2 u_satCounter (
        .ctr     (r_ctr[w_idxE]),
        .taken   (taken_e),
        .nextCtr (w_satNext)
    );

    // A miss allocates a fresh entry with a weak counter in the resolved direction.
    assign w_ctrWrite = w_hitE ? w_satNext : (taken_e ? CTR_WT : CTR_WNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid           <= '0;
            r_branchCount     <= 32'd0;
            r_mispredictCount <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= INIT_CTR;
            end
        end else if (update_en_e) begin
            r_valid[w_idxE]   <= 1'b1;
            r_ctr[w_idxE]     <= w_ctrWrite;
            r_branchCount     <= r_branchCount + 32'd1;
            if (mispredict_e) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
        end
    end

    // Tags and targets carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst && update_en_e) begin
            r_tag[w_idxE] <= w_tagE;
            if (!w_hitE || taken_e) begin
                r_target[w_idxE] <= target_e;
            end
        end
    end

    assign branch_count     = r_branchCount;
    assign mispredict_count = r_mispredictCount;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Directed self-checking bench for branch_predictor_bht.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        predict_taken_f;
    logic [31:0] predict_target_f;
    logic        btb_hit_f;
    logic        update_en_e;
    logic [31:0] pc_e;
    logic        taken_e;
    logic [31:0] target_e;
    logic        mispredict_e;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [31:0] bc;
        logic [31:0] mc;
    } expItem_t;

    expItem_t    sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelBc = 32'd0;
    logic [31:0] modelMc = 32'd0;

    branch_predictor_bht dut (
        .clk              (clk),
        .rst              (rst),
        .pc_f             (pc_f),
        .predict_taken_f  (predict_taken_f),
        .predict_target_f (predict_target_f),
        .btb_hit_f        (btb_hit_f),
        .update_en_e      (update_en_e),
        .pc_e             (pc_e),
        .taken_e          (taken_e),
        .target_e         (target_e),
        .mispredict_e     (mispredict_e),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational lookup and counters mid-cycle,
    // then advance the counter model past the clock edge.
    task automatic step(input string name, input logic doRst, input logic upd,
                        input logic [31:0] pcE, input logic tk, input logic [31:0] tgt,
                        input logic mis, input logic [31:0] pcF,
                        input logic eHit, input logic eTaken, input logic [31:0] eTarget);
        expItem_t e;
        rst          = doRst;
        update_en_e  = upd;
        pc_e         = pcE;
        taken_e      = tk;
        target_e     = tgt;
        mispredict_e = mis;
        pc_f         = pcF;
        e.hit    = eHit;
        e.taken  = eTaken;
        e.target = eTarget;
        e.bc     = modelBc;
        e.mc     = modelMc;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        cmp({name, ".hit"},    {31'd0, btb_hit_f},       {31'd0, e.hit});
        cmp({name, ".taken"},  {31'd0, predict_taken_f}, {31'd0, e.taken});
        cmp({name, ".target"}, predict_target_f,         e.target);
        cmp({name, ".bcnt"},   branch_count,             e.bc);
        cmp({name, ".mcnt"},   mispredict_count,         e.mc);
        @(posedge clk);
        #1;
        if (doRst) begin
            modelBc = 32'd0;
            modelMc = 32'd0;
        end else if (upd) begin
            modelBc = modelBc + 32'd1;
            if (mis) modelMc = modelMc + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1; update_en_e = 1'b0; pc_e = 32'd0; taken_e = 1'b0;
        target_e = 32'd0; mispredict_e = 1'b0; pc_f = 32'h100;
        @(posedge clk);
        #1;
        //    name         rst upd pc_e      tk tgt       mis pc_f      hit tk target
        step("rstHold",    1, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000);
        step("coldLookup", 0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000);
        step("firstAlloc", 0, 1, 32'h100, 1, 32'h200, 1, 32'h100, 0, 0, 32'h000);
        step("afterAlloc", 0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200);
        step("upT1",       0, 1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 1, 32'h200);
        step("upT2",       0, 1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 1, 32'h200);
        step("upT3",       0, 1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 1, 32'h200);
        step("downNT1",    0, 1, 32'h100, 0, 32'h999, 1, 32'h100, 1, 1, 32'h200);
        step("afterNT1",   0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200);
        step("downNT2",    0, 1, 32'h100, 0, 32'h888, 0, 32'h100, 1, 1, 32'h200);
        step("afterNT2",   0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 0, 32'h200);
        step("downNT3",    0, 1, 32'h100, 0, 32'h777, 0, 32'h100, 1, 0, 32'h200);
        step("floorNT",    0, 1, 32'h100, 0, 32'h777, 0, 32'h100, 1, 0, 32'h200);
        step("floorUpT",   0, 1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 0, 32'h200);
        step("floorChk",   0, 1, 32'h100, 1, 32'h204, 0, 32'h100, 1, 0, 32'h200);
        step("newTarget",  0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h204);
        step("aliasUpd",   0, 1, 32'h200, 1, 32'h300, 0, 32'h200, 0, 0, 32'h000);
        step("aliasHit",   0, 0, 32'h000, 0, 32'h000, 0, 32'h200, 1, 1, 32'h300);
        step("aliasEvict", 0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000);
        step("ntAlloc",    0, 1, 32'h504, 0, 32'h600, 1, 32'h504, 0, 0, 32'h000);
        step("ntAllocHit", 0, 0, 32'h000, 0, 32'h000, 0, 32'h504, 1, 0, 32'h600);
        step("lowBitsIgn", 0, 0, 32'h000, 0, 32'h000, 0, 32'h507, 1, 0, 32'h600);
        step("sameCycle",  0, 1, 32'h400, 1, 32'h480, 0, 32'h400, 0, 0, 32'h000);
        step("sameNext",   0, 0, 32'h000, 0, 32'h000, 0, 32'h400, 1, 1, 32'h480);
        step("rstWithUpd", 1, 1, 32'h504, 1, 32'h700, 1, 32'h400, 0, 0, 32'h000);
        step("postRstA",   0, 0, 32'h000, 0, 32'h000, 0, 32'h400, 0, 0, 32'h000);
        step("postRstB",   0, 0, 32'h000, 0, 32'h000, 0, 32'h504, 0, 0, 32'h000);
        step("reAlloc",    0, 1, 32'h504, 1, 32'h640, 0, 32'h504, 0, 0, 32'h000);
        step("reAllocHit", 0, 0, 32'h000, 0, 32'h000, 0, 32'h504, 1, 1, 32'h640);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
